instr_load_ctrl: RTL

Sequencer that drives the instruction-stream source (syn/ack/last handshake) to fill the MIPS pipeline's instruction memory before execution. Asserts the source request, captures each acknowledged word, and writes it to consecutive imem addresses. Holds the CPU in stall until a complete, error-free load finishes. Sits between the stream source, the imem write port and the pipeline's global hold input.

---
 rtl/instr_load_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instr_load_ctrl.sv
// instr_load_ctrl: fills the instruction memory from a syn/ack/last stream
// source before execution. While the load runs, the CPU is held in stall.
// A load ends in one of three ways:
//   - success: the word flagged last has been written
//   - error:   the source stays silent for too long, or sends more words
//              than the memory can hold
//   - abort:   the load is cancelled and the block returns to idle
module instr_load_ctrl #(
  parameter int IWIDTH  = 32,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              l_clk,
  input  logic              l_rst,
  input  logic              l_i_start,
  input  logic              l_i_abort,
  output logic              l_o_syn,
  input  logic [IWIDTH-1:0] l_i_instr,
  input  logic              l_i_ack,
  input  logic              l_i_last,
  output logic              l_o_imem_we,
  output logic [AWIDTH-1:0] l_o_imem_addr,
  output logic [IWIDTH-1:0] l_o_imem_data,
  output logic              l_o_cpu_hold,
  output logic              l_o_busy,
  output logic              l_o_done,
  output logic              l_o_err,
  output logic [AWIDTH:0]   l_o_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Word count at which every imem address has been written.
  localparam logic [AWIDTH:0] FULL = {1'b1, {AWIDTH{1'b0}}};

  // Value of the silence counter on the final cycle allowed without an ack.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [AWIDTH:0]     count_d;
  logic                we_d;
  logic [AWIDTH-1:0]   addr_d;
  logic [IWIDTH-1:0]   data_d;

  // Next-state and datapath decisions.
  // Within a load, the first matching rule applies:
  //   1. abort outranks everything else;
  //   2. an ack into a full memory is an error;
  //   3. otherwise an ack writes the word;
  //   4. otherwise the silence counter advances toward the timeout.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    count_d = l_o_count;
    we_d    = 1'b0;
    addr_d  = l_o_imem_addr;
    data_d  = l_o_imem_data;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (l_i_start) begin
          state_d = LOAD;
          count_d = '0;
          tcnt_d  = '0;
        end
      end
      LOAD: begin
        if (l_i_abort) begin
          state_d = IDLE;
        end else if (l_i_ack) begin
          if (l_o_count == FULL) begin
            state_d = ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = l_o_count[AWIDTH-1:0];
            data_d  = l_i_instr;
            count_d = l_o_count + 1'b1;
            tcnt_d  = '0;
            if (l_i_last) state_d = DONE;
          end
        end else begin
          if (tcnt_q == TLAST) state_d = ERR;
          else                 tcnt_d  = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register the state and all outputs.
  // Status flags are decoded from the next state, so each flag changes on
  // the same edge as the transition that causes it.
  always_ff @(posedge l_clk) begin
    if (l_rst) begin
      state_q       <= IDLE;
      tcnt_q        <= '0;
      l_o_count     <= '0;
      l_o_imem_we   <= 1'b0;
      l_o_imem_addr <= '0;
      l_o_imem_data <= '0;
      l_o_syn       <= 1'b0;
      l_o_busy      <= 1'b0;
      l_o_done      <= 1'b0;
      l_o_err       <= 1'b0;
      l_o_cpu_hold  <= 1'b1;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      l_o_count     <= count_d;
      l_o_imem_we   <= we_d;
      l_o_imem_addr <= addr_d;
      l_o_imem_data <= data_d;
      l_o_syn       <= (state_d == LOAD);
      l_o_busy      <= (state_d == LOAD);
      l_o_done      <= (state_d == DONE);
      l_o_err       <= (state_d == ERR);
      l_o_cpu_hold  <= (state_d != DONE);
    end
  end

endmodule
